// File: rtl/multiply_quantize_pipe_if.sv
// Handshake bundle for multiply_quantize_pipe: input beat, output beat and saturation counter.
// "master" is the upstream/downstream side and "slave" is the pipe itself.
interface multiply_quantize_pipe_if #(
   parameter int NBITS     = 16,
   parameter int NPARALLEL = 4
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [NBITS-1:0] ina [NPARALLEL];
   logic signed [NBITS-1:0] inb;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [NBITS-1:0] vout [NPARALLEL];
   logic [NPARALLEL-1:0]    vsat;
   logic [15:0]             sat_count;
   logic                    sat_clr;

   modport master (
      output in_valid, ina, inb, out_ready, sat_clr,
      input  in_ready, out_valid, vout, vsat, sat_count
   );
   modport slave (
      input  in_valid, ina, inb, out_ready, sat_clr,
      output in_ready, out_valid, vout, vsat, sat_count
   );
endinterface

// File: rtl/multiply_quantize_pipe.sv
// Two-stage lane multiplier: S1 holds exact products, S2 holds quantized results.
// Each stage advances when its downstream slot is empty or being drained.
module multiply_quantize_lane #(
   parameter int NBITS     = 16,
   parameter int FRAC_BITS = 16,
   parameter int ROUND     = 0,
   parameter int SATURATE  = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    s1_en,
   input  logic                    s2_en,
   input  logic signed [NBITS-1:0] a,
   input  logic signed [NBITS-1:0] b,
   output logic signed [NBITS-1:0] q_out,
   output logic                    ovf_out
);
   localparam int PW  = 2 * NBITS;
   localparam int RW  = PW + 1;
   localparam int RSH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
   localparam logic [RW-1:0] RND = (ROUND != 0 && FRAC_BITS > 0) ?
                                   ({{(RW-1){1'b0}}, 1'b1} << RSH) : '0;
   localparam logic [NBITS-1:0] MAXV = {1'b0, {(NBITS-1){1'b1}}};
   localparam logic [NBITS-1:0] MINV = {1'b1, {(NBITS-1){1'b0}}};

   logic signed [PW-1:0]  prod;
   logic signed [RW-1:0]  r;
   logic signed [RW-1:0]  q;
   logic [NBITS+1:0]      hi;
   logic                  ovf;
   logic [NBITS-1:0]      qv;

   always_ff @(posedge clk) begin
      if (s1_en) prod <= PW'(a) * PW'(b);
   end

   // One guard bit above the product keeps the rounding add from overflowing.
   always_comb begin
      r   = {prod[PW-1], prod} + RND;
      q   = r >>> FRAC_BITS;
      hi  = q[RW-1:NBITS-1];
      ovf = !((&hi) || !(|hi));
      qv  = q[NBITS-1:0];
      if (SATURATE != 0 && ovf) qv = q[RW-1] ? MINV : MAXV;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_out   <= '0;
         ovf_out <= 1'b0;
      end else if (s2_en) begin
         q_out   <= qv;
         ovf_out <= ovf;
      end
   end
endmodule

module multiply_quantize_pipe #(
   parameter int NBITS     = 16,
   parameter int NPARALLEL = 4,
   parameter int FRAC_BITS = 16,
   parameter int ROUND     = 0,
   parameter int SATURATE  = 0
) (
   input logic                    clk,
   input logic                    rst_n,
   multiply_quantize_pipe_if.slave bus
);
   logic s1_valid;
   logic s1_en;
   logic s2_en;

   always_comb begin
      s2_en = !bus.out_valid || bus.out_ready;
      s1_en = !s1_valid || s2_en;
   end

   assign bus.in_ready = s1_en;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid      <= 1'b0;
         bus.out_valid <= 1'b0;
      end else begin
         if (s1_en) s1_valid      <= bus.in_valid;
         if (s2_en) bus.out_valid <= s1_valid;
      end
   end

   // Clear wins over a same-cycle increment; the counter sticks at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n || bus.sat_clr)
         bus.sat_count <= '0;
      else if (bus.out_valid && bus.out_ready && (|bus.vsat) && bus.sat_count != 16'hFFFF)
         bus.sat_count <= bus.sat_count + 16'd1;
   end

   for (genvar i = 0; i < NPARALLEL; i++) begin : g_lane
      multiply_quantize_lane #(
         .NBITS(NBITS), .FRAC_BITS(FRAC_BITS), .ROUND(ROUND), .SATURATE(SATURATE)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .s1_en   (s1_en),
         .s2_en   (s2_en),
         .a       (bus.ina[i]),
         .b       (bus.inb),
         .q_out   (bus.vout[i]),
         .ovf_out (bus.vsat[i])
      );
   end
endmodule

// File: tb/tb_multiply_quantize_pipe.sv
// Four pipe instances (trunc/wrap and round/saturate at FRAC 16 and 8) run in lockstep
// on shared stimulus and are scored against an integer-arithmetic quantizer model.
module tb_multiply_quantize_pipe;
   localparam int NL = 4;
   localparam int ND = 4;

   typedef struct packed {
      logic [NL-1:0][15:0] a;
      logic [15:0]         b;
   } beat_t;

   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, sat_clr = 1'b0;
   logic [15:0] ina [NL];
   logic [15:0] inb = '0;
   logic        ir [ND];
   logic        ov [ND];
   logic [15:0] vo [ND][NL];
   logic [NL-1:0] vs [ND];
   logic [15:0] sc [ND];

   always #5 clk = ~clk;

   for (genvar k = 0; k < ND; k++) begin : g_dut
      multiply_quantize_pipe_if #(.NBITS(16), .NPARALLEL(NL)) bus ();
      multiply_quantize_pipe #(
         .NBITS(16), .NPARALLEL(NL), .FRAC_BITS(k < 2 ? 16 : 8),
         .ROUND(k % 2), .SATURATE(k % 2)
      ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
      assign bus.in_valid  = in_valid;
      assign bus.inb       = inb;
      assign bus.out_ready = out_ready;
      assign bus.sat_clr   = sat_clr;
      assign ir[k] = bus.in_ready;
      assign ov[k] = bus.out_valid;
      assign vs[k] = bus.vsat;
      assign sc[k] = bus.sat_count;
      for (genvar l = 0; l < NL; l++) begin : g_l
         assign bus.ina[l] = ina[l];
         assign vo[k][l]   = bus.vout[l];
      end
   end

   int          checks = 0, errors = 0;
   bit          acc, hs, orphan;
   logic        obs_ov [ND];
   logic        obs_ir [ND];
   logic [15:0] obs_vo [ND][NL];
   logic [NL-1:0] obs_vs [ND];
   logic [15:0] exp_vo [ND][NL];
   logic [NL-1:0] exp_vs [ND];
   logic [15:0] msc [ND];
   beat_t       mq [$];

   // Reference quantizer: exact product, optional half-up bias, floor shift, clamp or wrap.
   function automatic void qref(input logic [15:0] a, input logic [15:0] b, input int k,
                                output logic [15:0] v, output logic o);
      int     fr;
      longint p, q;
      fr = (k < 2) ? 16 : 8;
      p  = longint'($signed(a)) * longint'($signed(b));
      if (k % 2 == 1) p = p + (longint'(1) <<< (fr - 1));
      q  = p >>> fr;
      o  = (q > 32767) || (q < -32768);
      if (k % 2 == 1 && o) v = (q < 0) ? 16'h8000 : 16'h7FFF;
      else                 v = q[15:0];
   endfunction

   // One clock: sample at negedge, advance the model at the edge, return 1 time unit later.
   task automatic cycle();
      beat_t bt;
      @(negedge clk);
      acc    = in_valid && ir[0] && rst_n;
      hs     = ov[0] && out_ready && rst_n;
      orphan = 1'b0;
      for (int k = 0; k < ND; k++) begin
         obs_ov[k] = ov[k];
         obs_ir[k] = ir[k];
         obs_vs[k] = vs[k];
         for (int l = 0; l < NL; l++) obs_vo[k][l] = vo[k][l];
      end
      if (acc) begin
         for (int l = 0; l < NL; l++) bt.a[l] = ina[l];
         bt.b = inb;
         mq.push_back(bt);
      end
      if (hs) begin
         if (mq.size() == 0) orphan = 1'b1;
         else begin
            bt = mq.pop_front();
            for (int k = 0; k < ND; k++)
               for (int l = 0; l < NL; l++) qref(bt.a[l], bt.b, k, exp_vo[k][l], exp_vs[k][l]);
         end
      end
      @(posedge clk);
      for (int k = 0; k < ND; k++) begin
         if (!rst_n || sat_clr) msc[k] = '0;
         else if (hs && !orphan && (|exp_vs[k]) && msc[k] != 16'hFFFF) msc[k] = msc[k] + 16'd1;
      end
      if (!rst_n) mq.delete();
      #1;
   endtask

   task automatic set_lanes(input logic [15:0] a0, a1, a2, a3, input logic [15:0] b);
      ina[0] = a0; ina[1] = a1; ina[2] = a2; ina[3] = a3; inb = b;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      set_lanes(16'h1234, 16'h8000, 16'h7FFF, 16'h0001, 16'h7FFF);
      cycle(); cycle();
      for (int k = 0; k < ND; k++) begin
         checks++;
         if (ov[k] !== 1'b0 || vs[k] !== '0 || sc[k] !== 16'h0) begin
            errors++;
            $display("FAIL reset dut%0d: got out_valid=%b vsat=%b sat_count=%h want 0/0/0", k, ov[k], vs[k], sc[k]);
         end
         for (int l = 0; l < NL; l++) begin
            checks++;
            if (vo[k][l] !== 16'h0) begin
               errors++;
               $display("FAIL reset_vout dut%0d lane%0d: got %h want 0000", k, l, vo[k][l]);
            end
         end
      end
      rst_n = 1'b1;
      cycle();
      checks++;
      if (obs_ir[0] !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got in_ready=%b want 1", obs_ir[0]);
      end
   endtask

   task automatic test_legacy();
      logic [15:0] t1 [NL] = '{16'h1000, 16'hF000, 16'h0000, 16'h1FFF};
      out_ready = 1'b1; in_valid = 1'b1;
      set_lanes(16'h4000, 16'hC000, 16'h0001, 16'h7FFF, 16'h4000);
      cycle();
      checks++;
      if (!acc) begin errors++; $display("FAIL legacy_accept: got accept=0 want 1"); end
      in_valid = 1'b0;
      cycle();
      checks++;
      if (obs_ov[0] !== 1'b0) begin errors++; $display("FAIL legacy_latency1: got out_valid=%b want 0", obs_ov[0]); end
      cycle();
      checks++;
      if (!hs || orphan) begin
         errors++; $display("FAIL legacy_latency2: got handshake=%b want 1", hs);
      end else begin
         for (int l = 0; l < NL; l++) begin
            checks++;
            if (obs_vo[0][l] !== t1[l]) begin
               errors++; $display("FAIL legacy_vout lane%0d: got %h want %h", l, obs_vo[0][l], t1[l]);
            end
         end
         checks++;
         if (obs_vs[0] !== 4'b0) begin errors++; $display("FAIL legacy_vsat: got %b want 0000", obs_vs[0]); end
         for (int k = 1; k < ND; k++)
            for (int l = 0; l < NL; l++) begin
               checks++;
               if (obs_vo[k][l] !== exp_vo[k][l] || obs_vs[k][l] !== exp_vs[k][l]) begin
                  errors++;
                  $display("FAIL legacy_model dut%0d lane%0d: got %h/%b want %h/%b", k, l, obs_vo[k][l], obs_vs[k][l], exp_vo[k][l], exp_vs[k][l]);
               end
            end
      end
   endtask

   task automatic test_round();
      out_ready = 1'b1; in_valid = 1'b1;
      set_lanes(16'h0006, 16'h0000, 16'h0000, 16'h0000, 16'h4000);
      cycle(); in_valid = 1'b0; cycle(); cycle();
      checks++;
      if (!hs || obs_vo[0][0] !== 16'h0001 || obs_vo[1][0] !== 16'h0002) begin
         errors++;
         $display("FAIL round: got hs=%b trunc=%h round=%h want 1/0001/0002", hs, obs_vo[0][0], obs_vo[1][0]);
      end
   endtask

   task automatic test_sat();
      out_ready = 1'b1; in_valid = 1'b0; sat_clr = 1'b1;
      cycle();
      sat_clr = 1'b0;
      for (int k = 0; k < ND; k++) begin
         checks++;
         if (sc[k] !== 16'h0) begin errors++; $display("FAIL sat_clr dut%0d: got %h want 0000", k, sc[k]); end
      end
      in_valid = 1'b1;
      set_lanes(16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF);
      cycle(); in_valid = 1'b0; cycle(); cycle();
      checks++;
      if (!hs || obs_vo[2][0] !== 16'hFF00 || obs_vs[2] !== 4'b0001) begin
         errors++; $display("FAIL sat_wrap: got hs=%b vout=%h vsat=%b want 1/ff00/0001", hs, obs_vo[2][0], obs_vs[2]);
      end
      checks++;
      if (obs_vo[3][0] !== 16'h7FFF || obs_vs[3] !== 4'b0001) begin
         errors++; $display("FAIL sat_clamp: got vout=%h vsat=%b want 7fff/0001", obs_vo[3][0], obs_vs[3]);
      end
      checks++;
      if (sc[3] !== 16'h1 || sc[2] !== 16'h1) begin
         errors++; $display("FAIL sat_count: got %h/%h want 0001/0001", sc[2], sc[3]);
      end
   endtask

   task automatic test_back_to_back();
      int idx = 0, got = 0;
      bit prev_stall = 1'b0;
      logic [15:0] pvo [ND][NL];
      logic [NL-1:0] pvs [ND];
      for (int c = 0; c < 200 && got < 8; c++) begin
         in_valid  = (idx < 8);
         set_lanes(16'(idx), 16'(idx), 16'(idx), 16'(idx), 16'($urandom));
         out_ready = 1'($urandom_range(0, 1));
         cycle();
         if (acc) idx++;
         if (prev_stall)
            for (int k = 0; k < ND; k++) begin
               checks++;
               if (obs_ov[k] !== 1'b1 || obs_vs[k] !== pvs[k] || obs_vo[k] !== pvo[k]) begin
                  errors++; $display("FAIL b2b_hold dut%0d: got valid=%b vsat=%b vout0=%h want 1/%b/%h", k, obs_ov[k], obs_vs[k], obs_vo[k][0], pvs[k], pvo[k][0]);
               end
            end
         prev_stall = obs_ov[0] && !hs;
         pvo = obs_vo; pvs = obs_vs;
         if (hs) begin
            got++;
            checks++;
            if (orphan) begin errors++; $display("FAIL b2b_orphan: got extra beat want none"); end
            else for (int k = 0; k < ND; k++)
               for (int l = 0; l < NL; l++)
                  if (obs_vo[k][l] !== exp_vo[k][l] || obs_vs[k][l] !== exp_vs[k][l]) begin
                     errors++; $display("FAIL b2b_data dut%0d lane%0d: got %h/%b want %h/%b", k, l, obs_vo[k][l], obs_vs[k][l], exp_vo[k][l], exp_vs[k][l]);
                  end
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (got != 8 || idx != 8 || mq.size() != 0) begin
         errors++; $display("FAIL b2b_count: got out=%0d in=%0d pending=%0d want 8/8/0", got, idx, mq.size());
      end
   endtask

   task automatic test_fill();
      int nacc = 0;
      out_ready = 1'b0; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         set_lanes(16'(nacc + 100), 16'h8000, 16'(nacc), 16'h7FFF, 16'h0101);
         cycle();
         if (acc) nacc++;
      end
      checks++;
      if (nacc != 2 || obs_ir[0] !== 1'b0) begin
         errors++; $display("FAIL fill_accept: got accepted=%0d in_ready=%b want 2/0", nacc, obs_ir[0]);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         set_lanes(16'(nacc + 100), 16'h8000, 16'(nacc), 16'h7FFF, 16'h0101);
         cycle();
         if (acc) nacc++;
         if (nacc == 3) in_valid = 1'b0;
         checks++;
         if (!hs || orphan) begin
            errors++; $display("FAIL fill_drain cycle%0d: got handshake=%b want 1", c, hs);
         end else for (int k = 0; k < ND; k++)
            for (int l = 0; l < NL; l++)
               if (obs_vo[k][l] !== exp_vo[k][l] || obs_vs[k][l] !== exp_vs[k][l]) begin
                  errors++; $display("FAIL fill_data dut%0d lane%0d: got %h/%b want %h/%b", k, l, obs_vo[k][l], obs_vs[k][l], exp_vo[k][l], exp_vs[k][l]);
               end
      end
      cycle();
      checks++;
      if (hs || mq.size() != 0) begin
         errors++; $display("FAIL fill_empty: got handshake=%b pending=%0d want 0/0", hs, mq.size());
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 90; c++) begin
         if (c < 60) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            for (int l = 0; l < NL; l++) ina[l] = 16'($urandom);
            inb = 16'($urandom);
            if (c == 0) set_lanes(16'h8000, 16'h8000, 16'h7FFF, 16'h8000, 16'h8000);
            out_ready = 1'($urandom_range(0, 2) != 0);
            sat_clr   = 1'($urandom_range(0, 7) == 0);
         end else begin
            in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
         end
         cycle();
         if (hs) begin
            checks++;
            if (orphan) begin errors++; $display("FAIL rand_orphan cycle%0d: got extra beat want none", c); end
            else for (int k = 0; k < ND; k++)
               for (int l = 0; l < NL; l++)
                  if (obs_vo[k][l] !== exp_vo[k][l] || obs_vs[k][l] !== exp_vs[k][l]) begin
                     errors++; $display("FAIL rand_data dut%0d lane%0d: got %h/%b want %h/%b", k, l, obs_vo[k][l], obs_vs[k][l], exp_vo[k][l], exp_vs[k][l]);
                  end
         end
         for (int k = 0; k < ND; k++) begin
            checks++;
            if (sc[k] !== msc[k]) begin
               errors++; $display("FAIL rand_sat_count dut%0d cycle%0d: got %h want %h", k, c, sc[k], msc[k]);
            end
         end
      end
      checks++;
      if (mq.size() != 0 || ov[0] !== 1'b0) begin
         errors++; $display("FAIL rand_drain: got pending=%0d out_valid=%b want 0/0", mq.size(), ov[0]);
      end
   endtask

   task automatic test_reset_flight();
      out_ready = 1'b1; in_valid = 1'b1;
      set_lanes(16'h7FFF, 16'h0003, 16'h0004, 16'h0005, 16'h7FFF);
      cycle(); cycle();
      in_valid = 1'b0; rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      for (int k = 0; k < ND; k++) begin
         checks++;
         if (ov[k] !== 1'b0) begin errors++; $display("FAIL flight_reset dut%0d: got out_valid=%b want 0", k, ov[k]); end
      end
      for (int c = 0; c < 5; c++) begin
         cycle();
         checks++;
         if (obs_ov[0] !== 1'b0 || obs_ir[0] !== 1'b1) begin
            errors++; $display("FAIL flight_stale cycle%0d: got out_valid=%b in_ready=%b want 0/1", c, obs_ov[0], obs_ir[0]);
         end
      end
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      cycle();
      sat_clr = 1'b1;
      cycle();
      sat_clr = 1'b0;
      checks++;
      if (!hs || obs_vs[3] !== 4'b0001) begin
         errors++; $display("FAIL clr_setup: got handshake=%b vsat=%b want 1/0001", hs, obs_vs[3]);
      end
      for (int k = 0; k < ND; k++) begin
         checks++;
         if (sc[k] !== 16'h0) begin errors++; $display("FAIL clr_priority dut%0d: got %h want 0000", k, sc[k]); end
      end
   endtask

   initial begin
      for (int l = 0; l < NL; l++) ina[l] = '0;
      for (int k = 0; k < ND; k++) msc[k] = '0;
      test_reset();
      test_legacy();
      test_round();
      test_sat();
      test_back_to_back();
      test_fill();
      test_random();
      test_reset_flight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion want finish within time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
